// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, instruction memory requests and an in-order
// return queue feeding decode, with redirect and back-pressure.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [15:0] id_imm16
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]      pc;
  logic [31:0]      slot_pc   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] filled;
  ptr_t             head;
  ptr_t             tail;
  ptr_t             fill;
  cnt_t             outstanding;
  cnt_t             occupancy;
  cnt_t             drop;
  logic [31:0]      hold_instr;
  logic [31:0]      hold_pc;

  logic        head_full;
  logic        accept;
  logic        pop;
  logic        resp_keep;
  logic        resp_drop;
  logic [CW:0] credit;

  assign credit = {1'b0, outstanding}
                + {1'b0, occupancy};

  assign imem_req_valid = !reset
                       && !redirect_valid
                       && (credit < LIMIT);
  assign imem_addr = pc;
  assign accept = imem_req_valid
               && imem_req_ready;

  assign head_full = filled[head];
  assign id_valid  = head_full
                  && !redirect_valid
                  && !reset;
  assign pop = id_valid && id_ready;

  assign resp_keep = imem_resp_valid
                  && (drop == '0);
  assign resp_drop = imem_resp_valid
                  && (drop != '0);

  // Fields hold the last presented instruction while the head is empty.
  assign id_instr = head_full ? slot_data[head]
                              : hold_instr;
  assign id_pc    = head_full ? slot_pc[head]
                              : hold_pc;

  assign id_pc_plus4 = id_pc + 32'd4;
  assign id_opcode   = id_instr[31:26];
  assign id_rs       = id_instr[25:21];
  assign id_rt       = id_instr[20:16];
  assign id_imm16    = id_instr[15:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill        <= '0;
      filled      <= '0;
      outstanding <= '0;
      occupancy   <= '0;
      drop        <= '0;
      hold_instr  <= '0;
      hold_pc     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
    end else begin
      if (head_full) begin
        hold_instr <= slot_data[head];
        hold_pc    <= slot_pc[head];
      end
      if (redirect_valid) begin
        pc        <= redirect_pc & ~32'h3;
        head      <= '0;
        tail      <= '0;
        fill      <= '0;
        filled    <= '0;
        occupancy <= '0;
        // Everything still in flight belongs to the old path.
        outstanding <= outstanding
                     - cnt_t'(imem_resp_valid);
        drop        <= outstanding
                     - cnt_t'(imem_resp_valid);
      end else begin
        if (accept) begin
          slot_pc[tail] <= pc;
          tail          <= tail + ptr_t'(1);
          pc            <= pc + 32'd4;
        end
        if (pop) begin
          filled[head] <= 1'b0;
          head         <= head + ptr_t'(1);
        end
        if (resp_keep) begin
          slot_data[fill] <= imem_resp_data;
          filled[fill]    <= 1'b1;
          fill            <= fill + ptr_t'(1);
        end
        if (resp_drop) begin
          drop <= drop - cnt_t'(1);
        end
        outstanding <= outstanding
                     + cnt_t'(accept)
                     - cnt_t'(imem_resp_valid);
        occupancy   <= occupancy
                     + cnt_t'(resp_keep)
                     - cnt_t'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: in-order memory model with
// configurable latency, request/pop logs and directed checks.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [15:0] id_imm16;

  instruction_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .DEPTH(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .id_valid(id_valid),
    .id_instr(id_instr),
    .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode),
    .id_rs(id_rs),
    .id_rt(id_rt),
    .id_imm16(id_imm16)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] addr;
    int          cyc;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] p4;
    int          cyc;
  } pop_t;

  mreq_t mq[$];
  req_t  reqs[$];
  pop_t  pops[$];
  int    cyc;
  int    lat;
  int    passed;
  int    total;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a == 32'h0) ? 32'h2001_FFFF : ~a;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] pop_field(int i, int f);
    if (pops.size() <= i) return 32'hDEAD_BEEF;
    case (f)
      0: return pops[i].pc;
      1: return pops[i].instr;
      2: return 32'(pops[i].op);
      3: return 32'(pops[i].rs);
      4: return 32'(pops[i].rt);
      5: return 32'(pops[i].imm);
      6: return pops[i].p4;
      default: return 32'(pops[i].cyc);
    endcase
  endfunction

  function automatic int first_req_after(int c);
    foreach (reqs[i])
      if (reqs[i].cyc > c) return i;
    return -1;
  endfunction

  function automatic logic [31:0] req_addr(int i);
    if (i < 0 || reqs.size() <= i) return 32'hDEAD_BEEF;
    return reqs[i].addr;
  endfunction

  task automatic step();
    bit   acc;
    bit   pres;
    bit   rst;
    pop_t p;
    #1;
    assert (!(imem_resp_valid && mq.size() == 0))
      else $error("response without outstanding request");
    rst  = reset;
    acc  = !reset && imem_req_valid && imem_req_ready;
    pres = imem_resp_valid;
    if (acc) reqs.push_back('{imem_addr, cyc});
    if (!reset && id_valid && id_ready) begin
      p.pc    = id_pc;
      p.instr = id_instr;
      p.op    = id_opcode;
      p.rs    = id_rs;
      p.rt    = id_rt;
      p.imm   = id_imm16;
      p.p4    = id_pc_plus4;
      p.cyc   = cyc;
      pops.push_back(p);
    end
    @(posedge clock);
    #1;
    if (rst) begin
      mq.delete();
    end else begin
      if (pres && mq.size() > 0) void'(mq.pop_front());
      if (acc) mq.push_back('{reqs[$].addr, cyc + lat});
    end
    cyc++;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic reset_dut(int l, logic rdy);
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_req_ready = 1'b1;
    id_ready       = rdy;
    lat            = l;
    step();
    step();
    chk("rst_id_valid",  32'(id_valid), 32'h0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_id_instr",  id_instr, 32'h0);
    chk("rst_id_pc",     id_pc, 32'h0);
    reset = 1'b0;
    reqs.delete();
    pops.delete();
    cyc = 0;
    #1;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] p4;
  } vec_t;

  vec_t vt[4];
  int   idx;

  initial begin
    passed          = 0;
    total           = 0;
    cyc             = 0;
    lat             = 1;
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    id_ready        = 1'b1;

    vt[0] = '{32'h0, 32'h2001_FFFF, 6'h08, 5'h00,
              5'h01, 16'hFFFF, 32'h4};
    vt[1] = '{32'h4, 32'hFFFF_FFFB, 6'h3F, 5'h1F,
              5'h1F, 16'hFFFB, 32'h8};
    vt[2] = '{32'h8, 32'hFFFF_FFF7, 6'h3F, 5'h1F,
              5'h1F, 16'hFFF7, 32'hC};
    vt[3] = '{32'hC, 32'hFFFF_FFF3, 6'h3F, 5'h1F,
              5'h1F, 16'hFFF3, 32'h10};

    // 1: streaming fetch with decode always ready
    reset_dut(1, 1'b1);
    chk("t1_first_req_now", 32'(imem_req_valid), 32'h1);
    run(14);
    chk("t1_first_req_cyc",
        reqs.size() > 0 ? 32'(reqs[0].cyc) : 32'hFFFF, 32'h0);
    chk("t1_req0", req_addr(0), 32'h0);
    chk("t1_req1", req_addr(1), 32'h4);
    chk("t1_req2", req_addr(2), 32'h8);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_pc%0d", i),    pop_field(i, 0), vt[i].pc);
      chk($sformatf("t1_ins%0d", i),   pop_field(i, 1), vt[i].instr);
      chk($sformatf("t1_op%0d", i),    pop_field(i, 2), 32'(vt[i].op));
      chk($sformatf("t1_rs%0d", i),    pop_field(i, 3), 32'(vt[i].rs));
      chk($sformatf("t1_rt%0d", i),    pop_field(i, 4), 32'(vt[i].rt));
      chk($sformatf("t1_imm%0d", i),   pop_field(i, 5), 32'(vt[i].imm));
      chk($sformatf("t1_p4_%0d", i),   pop_field(i, 6), vt[i].p4);
    end

    // 2: back-pressure then release
    reset_dut(1, 1'b0);
    run(6);
    chk("t2_req_count", 32'(reqs.size()), 32'd2);
    chk("t2_req_stall", 32'(imem_req_valid), 32'h0);
    chk("t2_id_valid",  32'(id_valid), 32'h1);
    chk("t2_id_instr",  id_instr, 32'h2001_FFFF);
    id_ready = 1'b1;
    #1;
    run(5);
    chk("t2_pop0_pc", pop_field(0, 0), 32'h0);
    chk("t2_pop1_pc", pop_field(1, 0), 32'h4);
    chk("t2_pop_gap", pop_field(1, 7) - pop_field(0, 7), 32'h1);
    chk("t2_req2",    req_addr(2), 32'h8);

    // 3: redirect with two slow responses in flight
    reset_dut(3, 1'b1);
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    #1;
    chk("t3_req_blocked", 32'(imem_req_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    run(20);
    idx = first_req_after(2);
    chk("t3_next_addr", req_addr(idx), 32'h100);
    chk("t3_pop_pc",    pop_field(0, 0), 32'h100);
    chk("t3_pop_instr", pop_field(0, 1), 32'hFFFF_FEFF);

    // 4: redirect collides with pop and a response
    reset_dut(1, 1'b1);
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0040;
    #1;
    chk("t4_resp_present", 32'(imem_resp_valid), 32'h1);
    chk("t4_id_valid",     32'(id_valid), 32'h0);
    step();
    redirect_valid = 1'b0;
    #1;
    run(10);
    idx = first_req_after(2);
    chk("t4_next_addr", req_addr(idx), 32'h40);
    chk("t4_next_cyc",
        idx >= 0 ? 32'(reqs[idx].cyc) : 32'hFFFF, 32'd3);
    chk("t4_pop_pc",    pop_field(0, 0), 32'h40);
    chk("t4_pop_instr", pop_field(0, 1), 32'hFFFF_FFBF);

    // 5: redirect to the top word, PC wraps
    reset_dut(1, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1;
    step();
    redirect_valid = 1'b0;
    #1;
    run(10);
    chk("t5_req0",    req_addr(0), 32'hFFFF_FFFC);
    chk("t5_req1",    req_addr(1), 32'h0);
    chk("t5_pop0_pc", pop_field(0, 0), 32'hFFFF_FFFC);
    chk("t5_pop0_p4", pop_field(0, 6), 32'h0);
    chk("t5_pop0_in", pop_field(0, 1), 32'h0000_0003);
    chk("t5_pop1_in", pop_field(1, 1), 32'h2001_FFFF);

    // 6: reset while the queue is full
    reset_dut(1, 1'b0);
    run(5);
    chk("t6_full_noreq", 32'(imem_req_valid), 32'h0);
    chk("t6_full_instr", id_instr, 32'h2001_FFFF);
    step();
    chk("t6_hold_instr", id_instr, 32'h2001_FFFF);
    chk("t6_hold_pc",    id_pc, 32'h0);
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
    #1;
    chk("t6_post_valid", 32'(id_valid), 32'h0);
    chk("t6_post_req",   32'(imem_req_valid), 32'h1);
    chk("t6_post_addr",  imem_addr, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
